// File: rtl/ex_level_if.sv
// EX/MEM pipeline register bundle: the execute stage drives it, the memory stage consumes it.
interface ex_level_if #(
    parameter int WIDTH_INSTR = 6
);
    logic [WIDTH_INSTR-1:0] instr_MEM;
    logic [31:0]            PC_MEM;
    logic [31:0]            aluOut_MEM;
    logic [31:0]            dataRt_MEM;
    logic [4:0]             regWriteAddr_MEM;
    logic [31:0]            regWriteData_MEM;

    modport master (
        output instr_MEM,
        output PC_MEM,
        output aluOut_MEM,
        output dataRt_MEM,
        output regWriteAddr_MEM,
        output regWriteData_MEM
    );

    modport slave (
        input instr_MEM,
        input PC_MEM,
        input aluOut_MEM,
        input dataRt_MEM,
        input regWriteAddr_MEM,
        input regWriteData_MEM
    );
endinterface

// File: rtl/ex_level.sv
// MIPS execute stage: operand forwarding, ALU, multi-cycle MDU with HI/LO, EX/MEM register.
module ex_level #(
    parameter int WIDTH_INSTR = 6,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH_INSTR-1:0] instr_EX,
    input  logic [31:0]            PC_EX,
    input  logic [31:0]            dataRs_EX,
    input  logic [31:0]            dataRt_EX,
    input  logic [15:0]            imm16_EX,
    input  logic [4:0]             shamt_EX,
    input  logic [4:0]             addrRs_EX,
    input  logic [4:0]             addrRt_EX,
    input  logic [4:0]             regWriteAddr_EX,
    input  logic [31:0]            regWriteData_EX,
    input  logic [4:0]             regaddr_MEM,
    input  logic [31:0]            regdata_MEM,
    input  logic [4:0]             regaddr_WB,
    input  logic [31:0]            regdata_WB,
    output logic [4:0]             regaddr_EX,
    output logic [31:0]            regdata_EX,
    output logic                   md_busy,
    ex_level_if.master             memBus
);
    localparam logic [WIDTH_INSTR-1:0] I_ADD   = WIDTH_INSTR'(1);
    localparam logic [WIDTH_INSTR-1:0] I_ADDU  = WIDTH_INSTR'(2);
    localparam logic [WIDTH_INSTR-1:0] I_SUB   = WIDTH_INSTR'(3);
    localparam logic [WIDTH_INSTR-1:0] I_SUBU  = WIDTH_INSTR'(4);
    localparam logic [WIDTH_INSTR-1:0] I_AND   = WIDTH_INSTR'(5);
    localparam logic [WIDTH_INSTR-1:0] I_OR    = WIDTH_INSTR'(6);
    localparam logic [WIDTH_INSTR-1:0] I_XOR   = WIDTH_INSTR'(7);
    localparam logic [WIDTH_INSTR-1:0] I_NOR   = WIDTH_INSTR'(8);
    localparam logic [WIDTH_INSTR-1:0] I_SLT   = WIDTH_INSTR'(9);
    localparam logic [WIDTH_INSTR-1:0] I_SLTU  = WIDTH_INSTR'(10);
    localparam logic [WIDTH_INSTR-1:0] I_SLL   = WIDTH_INSTR'(11);
    localparam logic [WIDTH_INSTR-1:0] I_SRL   = WIDTH_INSTR'(12);
    localparam logic [WIDTH_INSTR-1:0] I_SRA   = WIDTH_INSTR'(13);
    localparam logic [WIDTH_INSTR-1:0] I_SLLV  = WIDTH_INSTR'(14);
    localparam logic [WIDTH_INSTR-1:0] I_SRLV  = WIDTH_INSTR'(15);
    localparam logic [WIDTH_INSTR-1:0] I_SRAV  = WIDTH_INSTR'(16);
    localparam logic [WIDTH_INSTR-1:0] I_ADDI  = WIDTH_INSTR'(17);
    localparam logic [WIDTH_INSTR-1:0] I_ADDIU = WIDTH_INSTR'(18);
    localparam logic [WIDTH_INSTR-1:0] I_ANDI  = WIDTH_INSTR'(19);
    localparam logic [WIDTH_INSTR-1:0] I_ORI   = WIDTH_INSTR'(20);
    localparam logic [WIDTH_INSTR-1:0] I_XORI  = WIDTH_INSTR'(21);
    localparam logic [WIDTH_INSTR-1:0] I_SLTI  = WIDTH_INSTR'(22);
    localparam logic [WIDTH_INSTR-1:0] I_SLTIU = WIDTH_INSTR'(23);
    localparam logic [WIDTH_INSTR-1:0] I_LUI   = WIDTH_INSTR'(24);
    localparam logic [WIDTH_INSTR-1:0] I_LW    = WIDTH_INSTR'(25);
    localparam logic [WIDTH_INSTR-1:0] I_LB    = WIDTH_INSTR'(26);
    localparam logic [WIDTH_INSTR-1:0] I_LBU   = WIDTH_INSTR'(27);
    localparam logic [WIDTH_INSTR-1:0] I_LH    = WIDTH_INSTR'(28);
    localparam logic [WIDTH_INSTR-1:0] I_LHU   = WIDTH_INSTR'(29);
    localparam logic [WIDTH_INSTR-1:0] I_SW    = WIDTH_INSTR'(30);
    localparam logic [WIDTH_INSTR-1:0] I_SB    = WIDTH_INSTR'(31);
    localparam logic [WIDTH_INSTR-1:0] I_SH    = WIDTH_INSTR'(32);
    localparam logic [WIDTH_INSTR-1:0] I_JAL   = WIDTH_INSTR'(33);
    localparam logic [WIDTH_INSTR-1:0] I_JALR  = WIDTH_INSTR'(34);
    localparam logic [WIDTH_INSTR-1:0] I_MULT  = WIDTH_INSTR'(35);
    localparam logic [WIDTH_INSTR-1:0] I_MULTU = WIDTH_INSTR'(36);
    localparam logic [WIDTH_INSTR-1:0] I_DIV   = WIDTH_INSTR'(37);
    localparam logic [WIDTH_INSTR-1:0] I_DIVU  = WIDTH_INSTR'(38);
    localparam logic [WIDTH_INSTR-1:0] I_MFHI  = WIDTH_INSTR'(39);
    localparam logic [WIDTH_INSTR-1:0] I_MFLO  = WIDTH_INSTR'(40);
    localparam logic [WIDTH_INSTR-1:0] I_MTHI  = WIDTH_INSTR'(41);
    localparam logic [WIDTH_INSTR-1:0] I_MTLO  = WIDTH_INSTR'(42);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic { MD_IDLE, MD_BUSY } mdState_t;
    typedef enum logic [1:0] { OP_MULT, OP_MULTU, OP_DIV, OP_DIVU } mdOp_t;

    logic [31:0] rsVal, rtVal, immExt, aluResult, wbData;
    logic        aluWrites, isEarly, isMd;

    mdState_t          state, nextState;
    mdOp_t             mdOp, nextOp;
    logic [CNT_W-1:0]  cnt, nextCnt;
    logic [31:0]       hi, lo, nextHi, nextLo;
    logic [31:0]       opA, opB, nextOpA, nextOpB;
    logic [63:0]       prodS, prodU;
    logic [31:0]       quotS, remS, quotU, remU;

    // MEM is the younger producer, so it wins over WB; register 0 is never forwarded.
    always_comb begin
        rsVal = dataRs_EX;
        if (addrRs_EX != 5'd0 && regaddr_MEM == addrRs_EX)
            rsVal = regdata_MEM;
        else if (addrRs_EX != 5'd0 && regaddr_WB == addrRs_EX)
            rsVal = regdata_WB;
        rtVal = dataRt_EX;
        if (addrRt_EX != 5'd0 && regaddr_MEM == addrRt_EX)
            rtVal = regdata_MEM;
        else if (addrRt_EX != 5'd0 && regaddr_WB == addrRt_EX)
            rtVal = regdata_WB;
    end

    assign immExt = (instr_EX == I_ANDI || instr_EX == I_ORI || instr_EX == I_XORI)
                    ? {16'h0000, imm16_EX} : {{16{imm16_EX[15]}}, imm16_EX};

    assign isEarly = (instr_EX == I_JAL) || (instr_EX == I_JALR) || (instr_EX == I_LUI);
    assign isMd    = (instr_EX == I_MULT) || (instr_EX == I_MULTU) ||
                     (instr_EX == I_DIV)  || (instr_EX == I_DIVU);

    // Loads and stores produce an address in aluResult but write no register value here.
    always_comb begin
        aluResult = 32'h0;
        aluWrites = 1'b0;
        case (instr_EX)
            I_ADD, I_ADDU:   begin aluResult = rsVal + rtVal;  aluWrites = 1'b1; end
            I_ADDI, I_ADDIU: begin aluResult = rsVal + immExt; aluWrites = 1'b1; end
            I_SUB, I_SUBU:   begin aluResult = rsVal - rtVal;  aluWrites = 1'b1; end
            I_AND:   begin aluResult = rsVal & rtVal;    aluWrites = 1'b1; end
            I_OR:    begin aluResult = rsVal | rtVal;    aluWrites = 1'b1; end
            I_XOR:   begin aluResult = rsVal ^ rtVal;    aluWrites = 1'b1; end
            I_NOR:   begin aluResult = ~(rsVal | rtVal); aluWrites = 1'b1; end
            I_ANDI:  begin aluResult = rsVal & immExt;   aluWrites = 1'b1; end
            I_ORI:   begin aluResult = rsVal | immExt;   aluWrites = 1'b1; end
            I_XORI:  begin aluResult = rsVal ^ immExt;   aluWrites = 1'b1; end
            I_SLT:   begin aluResult = {31'b0, $signed(rsVal) < $signed(rtVal)};  aluWrites = 1'b1; end
            I_SLTU:  begin aluResult = {31'b0, rsVal < rtVal};                    aluWrites = 1'b1; end
            I_SLTI:  begin aluResult = {31'b0, $signed(rsVal) < $signed(immExt)}; aluWrites = 1'b1; end
            I_SLTIU: begin aluResult = {31'b0, rsVal < immExt};                   aluWrites = 1'b1; end
            I_SLL:   begin aluResult = rtVal << shamt_EX;               aluWrites = 1'b1; end
            I_SRL:   begin aluResult = rtVal >> shamt_EX;               aluWrites = 1'b1; end
            I_SRA:   begin aluResult = $signed(rtVal) >>> shamt_EX;     aluWrites = 1'b1; end
            I_SLLV:  begin aluResult = rtVal << rsVal[4:0];             aluWrites = 1'b1; end
            I_SRLV:  begin aluResult = rtVal >> rsVal[4:0];             aluWrites = 1'b1; end
            I_SRAV:  begin aluResult = $signed(rtVal) >>> rsVal[4:0];   aluWrites = 1'b1; end
            I_MFHI:  begin aluResult = hi; aluWrites = 1'b1; end
            I_MFLO:  begin aluResult = lo; aluWrites = 1'b1; end
            I_LW, I_LB, I_LBU, I_LH, I_LHU, I_SW, I_SB, I_SH: aluResult = rsVal + immExt;
            default: aluResult = 32'h0;
        endcase
        wbData = aluWrites ? aluResult : (isEarly ? regWriteData_EX : 32'h0);
    end

    assign regaddr_EX = isEarly ? regWriteAddr_EX : 5'd0;
    assign regdata_EX = regWriteData_EX;
    assign md_busy    = (state == MD_BUSY) || isMd;

    always_ff @(posedge clk) begin
        if (reset) begin
            memBus.instr_MEM        <= '0;
            memBus.PC_MEM           <= 32'h0;
            memBus.aluOut_MEM       <= 32'h0;
            memBus.dataRt_MEM       <= 32'h0;
            memBus.regWriteAddr_MEM <= 5'd0;
            memBus.regWriteData_MEM <= 32'h0;
        end else begin
            memBus.instr_MEM        <= instr_EX;
            memBus.PC_MEM           <= PC_EX;
            memBus.aluOut_MEM       <= aluResult;
            memBus.dataRt_MEM       <= rtVal;
            memBus.regWriteAddr_MEM <= regWriteAddr_EX;
            memBus.regWriteData_MEM <= wbData;
        end
    end

    assign prodS = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
    assign prodU = {32'h0, opA} * {32'h0, opB};
    assign quotS = $signed(opA) / $signed(opB);
    assign remS  = $signed(opA) % $signed(opB);
    assign quotU = opA / opB;
    assign remU  = opA % opB;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            mdOp  <= OP_MULT;
            cnt   <= '0;
            hi    <= 32'h0;
            lo    <= 32'h0;
            opA   <= 32'h0;
            opB   <= 32'h0;
        end else begin
            state <= nextState;
            mdOp  <= nextOp;
            cnt   <= nextCnt;
            hi    <= nextHi;
            lo    <= nextLo;
            opA   <= nextOpA;
            opB   <= nextOpB;
        end
    end

    // An MD instruction arriving while busy is dropped; MTHI/MTLO land after any completion write.
    always_comb begin
        nextState = state;
        nextOp    = mdOp;
        nextCnt   = cnt;
        nextHi    = hi;
        nextLo    = lo;
        nextOpA   = opA;
        nextOpB   = opB;
        case (state)
            MD_IDLE: begin
                if (isMd) begin
                    nextState = MD_BUSY;
                    nextOpA   = rsVal;
                    nextOpB   = rtVal;
                    case (instr_EX)
                        I_MULT:  nextOp = OP_MULT;
                        I_MULTU: nextOp = OP_MULTU;
                        I_DIV:   nextOp = OP_DIV;
                        default: nextOp = OP_DIVU;
                    endcase
                    nextCnt = (instr_EX == I_MULT || instr_EX == I_MULTU)
                              ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            MD_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    nextState = MD_IDLE;
                    nextCnt   = '0;
                    case (mdOp)
                        OP_MULT:  {nextHi, nextLo} = prodS;
                        OP_MULTU: {nextHi, nextLo} = prodU;
                        OP_DIV:   if (opB != 32'h0) begin nextLo = quotS; nextHi = remS; end
                        default:  if (opB != 32'h0) begin nextLo = quotU; nextHi = remU; end
                    endcase
                end else begin
                    nextCnt = cnt - CNT_W'(1);
                end
            end
            default: nextState = MD_IDLE;
        endcase
        if (instr_EX == I_MTHI) nextHi = rsVal;
        if (instr_EX == I_MTLO) nextLo = rsVal;
    end
endmodule

// File: tb/tb_ex_level.sv
// Directed-vector bench for ex_level: ALU, forwarding, EX/MEM register, MDU timing and reset.
module tb_ex_level;
    localparam int W = 6;
    localparam logic [W-1:0] I_NOP = 6'd0,  I_ADD = 6'd1,  I_ADDU = 6'd2, I_SUBU = 6'd4;
    localparam logic [W-1:0] I_NOR = 6'd8,  I_SRA = 6'd13, I_SRLV = 6'd15, I_ADDIU = 6'd18;
    localparam logic [W-1:0] I_ANDI = 6'd19, I_SLTI = 6'd22, I_SLTIU = 6'd23, I_LW = 6'd25;
    localparam logic [W-1:0] I_SW = 6'd30, I_JAL = 6'd33, I_MULT = 6'd35, I_DIV = 6'd37;
    localparam logic [W-1:0] I_DIVU = 6'd38, I_MFHI = 6'd39, I_MFLO = 6'd40, I_MTLO = 6'd42;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  instr_EX;
    logic [31:0]   PC_EX, dataRs_EX, dataRt_EX, regWriteData_EX, regdata_MEM, regdata_WB;
    logic [15:0]   imm16_EX;
    logic [4:0]    shamt_EX, addrRs_EX, addrRt_EX, regWriteAddr_EX, regaddr_MEM, regaddr_WB;
    logic [4:0]    regaddr_EX;
    logic [31:0]   regdata_EX;
    logic          md_busy;
    int            vectors = 0;
    int            miscompares = 0;

    ex_level_if #(.WIDTH_INSTR(W)) memBus ();

    ex_level #(.WIDTH_INSTR(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .instr_EX(instr_EX), .PC_EX(PC_EX),
        .dataRs_EX(dataRs_EX), .dataRt_EX(dataRt_EX), .imm16_EX(imm16_EX),
        .shamt_EX(shamt_EX), .addrRs_EX(addrRs_EX), .addrRt_EX(addrRt_EX),
        .regWriteAddr_EX(regWriteAddr_EX), .regWriteData_EX(regWriteData_EX),
        .regaddr_MEM(regaddr_MEM), .regdata_MEM(regdata_MEM),
        .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
        .regaddr_EX(regaddr_EX), .regdata_EX(regdata_EX), .md_busy(md_busy),
        .memBus(memBus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm, input logic [4:0] sh, input logic [4:0] aRs,
                                 input logic [4:0] aRt, input logic [4:0] wa, input logic [31:0] wd);
        instr_EX = op; dataRs_EX = rs; dataRt_EX = rt; imm16_EX = imm; shamt_EX = sh;
        addrRs_EX = aRs; addrRt_EX = aRt; regWriteAddr_EX = wa; regWriteData_EX = wd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nop();
        applyStimulus(I_NOP, 0, 0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; PC_EX = 32'h0;
        regaddr_MEM = 5'd0; regdata_MEM = 32'h0; regaddr_WB = 5'd0; regdata_WB = 32'h0;
        applyStimulus(I_ADDU, 32'h5, 32'h6, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        PC_EX = 32'h0000_0400;
        tick(); tick();
        checkOutput("rst_instr", 32'(memBus.instr_MEM), 32'h0);
        checkOutput("rst_pc", memBus.PC_MEM, 32'h0);
        checkOutput("rst_alu", memBus.aluOut_MEM, 32'h0);
        checkOutput("rst_rt", memBus.dataRt_MEM, 32'h0);
        checkOutput("rst_waddr", 32'(memBus.regWriteAddr_MEM), 32'h0);
        checkOutput("rst_wdata", memBus.regWriteData_MEM, 32'h0);
        checkOutput("rst_busy", 32'(md_busy), 32'h0);
        reset = 1'b0;

        $display("[TB] ALU and immediates");
        applyStimulus(I_ADDU, 32'h7FFF_FFFF, 32'h1, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0); tick();
        checkOutput("addu_wdata", memBus.regWriteData_MEM, 32'h8000_0000);
        checkOutput("addu_alu", memBus.aluOut_MEM, 32'h8000_0000);
        checkOutput("addu_waddr", 32'(memBus.regWriteAddr_MEM), 32'd3);
        checkOutput("addu_pc", memBus.PC_MEM, 32'h0000_0400);
        checkOutput("addu_instr", 32'(memBus.instr_MEM), 32'(I_ADDU));
        applyStimulus(I_ADD, 32'h7FFF_FFFF, 32'h1, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0); tick();
        checkOutput("add_wdata", memBus.regWriteData_MEM, 32'h8000_0000);
        applyStimulus(I_SLTI, 32'hFFFF_FFFF, 32'h0, 16'h0001, 5'd0, 5'd1, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("slti", memBus.regWriteData_MEM, 32'h1);
        applyStimulus(I_SLTIU, 32'hFFFF_FFFF, 32'h0, 16'h0001, 5'd0, 5'd1, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("sltiu", memBus.regWriteData_MEM, 32'h0);
        applyStimulus(I_ANDI, 32'hFFFF_FFFF, 32'h0, 16'h8000, 5'd0, 5'd1, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("andi", memBus.regWriteData_MEM, 32'h0000_8000);
        applyStimulus(I_ADDIU, 32'h10, 32'h0, 16'hFFFF, 5'd0, 5'd1, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("addiu_neg", memBus.regWriteData_MEM, 32'h0000_000F);
        applyStimulus(I_SRA, 32'h0, 32'h8000_0000, 16'h0, 5'd4, 5'd0, 5'd2, 5'd3, 32'h0); tick();
        checkOutput("sra", memBus.regWriteData_MEM, 32'hF800_0000);
        applyStimulus(I_SRLV, 32'h4, 32'h8000_0000, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0); tick();
        checkOutput("srlv", memBus.regWriteData_MEM, 32'h0800_0000);
        applyStimulus(I_NOR, 32'h0, 32'h0F0F_0F0F, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0); tick();
        checkOutput("nor", memBus.regWriteData_MEM, 32'hF0F0_F0F0);
        applyStimulus(I_SUBU, 32'h0, 32'h1, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0); tick();
        checkOutput("subu", memBus.regWriteData_MEM, 32'hFFFF_FFFF);

        $display("[TB] forwarding and memory ops");
        regaddr_MEM = 5'd5; regdata_MEM = 32'h11; regaddr_WB = 5'd5; regdata_WB = 32'h22;
        applyStimulus(I_ADDU, 32'h99, 32'h0, 16'h0, 5'd0, 5'd5, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("fwd_mem", memBus.regWriteData_MEM, 32'h11);
        regaddr_MEM = 5'd6;
        applyStimulus(I_ADDU, 32'h99, 32'h0, 16'h0, 5'd0, 5'd5, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("fwd_wb", memBus.regWriteData_MEM, 32'h22);
        regaddr_MEM = 5'd0; regaddr_WB = 5'd0;
        applyStimulus(I_ADDU, 32'h33, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd3, 32'h0); tick();
        checkOutput("fwd_zero", memBus.regWriteData_MEM, 32'h33);
        regaddr_WB = 5'd7; regdata_WB = 32'h0000_ABCD;
        applyStimulus(I_SW, 32'h1000, 32'h0, 16'hFFFC, 5'd0, 5'd1, 5'd7, 5'd0, 32'h0); tick();
        checkOutput("sw_addr", memBus.aluOut_MEM, 32'h0000_0FFC);
        checkOutput("sw_data", memBus.dataRt_MEM, 32'h0000_ABCD);
        checkOutput("sw_wdata", memBus.regWriteData_MEM, 32'h0);
        regaddr_WB = 5'd0; regdata_WB = 32'h0; regdata_MEM = 32'h0;
        applyStimulus(I_LW, 32'h1000, 32'h0, 16'h0004, 5'd0, 5'd1, 5'd0, 5'd8, 32'h0); tick();
        checkOutput("lw_addr", memBus.aluOut_MEM, 32'h0000_1004);
        checkOutput("lw_wdata", memBus.regWriteData_MEM, 32'h0);
        checkOutput("lw_waddr", 32'(memBus.regWriteAddr_MEM), 32'd8);
        applyStimulus(I_JAL, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd31, 32'h1008);
        checkOutput("jal_fwd_addr", 32'(regaddr_EX), 32'd31);
        checkOutput("jal_fwd_data", regdata_EX, 32'h1008);
        tick();
        checkOutput("jal_wdata", memBus.regWriteData_MEM, 32'h1008);
        applyStimulus(I_ADDU, 32'h1, 32'h1, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        checkOutput("addu_fwd_addr", 32'(regaddr_EX), 32'd0);

        $display("[TB] multiply/divide unit");
        applyStimulus(I_MULT, 32'hFFFF_FFFF, 32'h2, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0);
        checkOutput("mult_issue_busy", 32'(md_busy), 32'h1);
        tick(); nop();
        for (int i = 0; i < 5; i++) begin
            checkOutput("mult_busy", 32'(md_busy), 32'h1);
            tick();
        end
        checkOutput("mult_done", 32'(md_busy), 32'h0);
        applyStimulus(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("mult_hi", memBus.regWriteData_MEM, 32'hFFFF_FFFF);
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("mult_lo", memBus.regWriteData_MEM, 32'hFFFF_FFFE);

        applyStimulus(I_DIV, 32'hFFFF_FFF9, 32'h2, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0);
        tick(); nop();
        for (int i = 0; i < 10; i++) begin
            checkOutput("div_busy", 32'(md_busy), 32'h1);
            tick();
        end
        checkOutput("div_done", 32'(md_busy), 32'h0);
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("div_lo", memBus.regWriteData_MEM, 32'hFFFF_FFFD);
        applyStimulus(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("div_hi", memBus.regWriteData_MEM, 32'hFFFF_FFFF);

        applyStimulus(I_DIVU, 32'h5, 32'h0, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0);
        tick(); nop();
        for (int i = 0; i < 10; i++) tick();
        checkOutput("divz_done", 32'(md_busy), 32'h0);
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("divz_lo", memBus.regWriteData_MEM, 32'hFFFF_FFFD);
        applyStimulus(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("divz_hi", memBus.regWriteData_MEM, 32'hFFFF_FFFF);

        applyStimulus(I_MTLO, 32'h55, 32'h0, 16'h0, 5'd0, 5'd1, 5'd0, 5'd0, 32'h0); tick();
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("mtlo", memBus.regWriteData_MEM, 32'h55);

        applyStimulus(I_MULT, 32'h3, 32'h4, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0); tick();
        applyStimulus(I_DIV, 32'd100, 32'd7, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0);
        checkOutput("ignored_md_busy", 32'(md_busy), 32'h1);
        tick(); nop();
        for (int i = 0; i < 4; i++) tick();
        checkOutput("ignored_done", 32'(md_busy), 32'h0);
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("ignored_lo", memBus.regWriteData_MEM, 32'd12);
        applyStimulus(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("ignored_hi", memBus.regWriteData_MEM, 32'h0);

        $display("[TB] reset during divide");
        applyStimulus(I_DIV, 32'd100, 32'd7, 16'h0, 5'd0, 5'd1, 5'd2, 5'd0, 32'h0);
        tick(); nop(); tick(); tick();
        applyStimulus(I_ADDU, 32'h1, 32'h2, 16'h0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nop();
        checkOutput("mdrst_busy", 32'(md_busy), 32'h0);
        checkOutput("mdrst_instr", 32'(memBus.instr_MEM), 32'h0);
        checkOutput("mdrst_wdata", memBus.regWriteData_MEM, 32'h0);
        checkOutput("mdrst_waddr", 32'(memBus.regWriteAddr_MEM), 32'h0);
        checkOutput("mdrst_rt", memBus.dataRt_MEM, 32'h0);
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("mdrst_lo", memBus.regWriteData_MEM, 32'h0);
        nop();
        for (int i = 0; i < 12; i++) tick();
        applyStimulus(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("mdrst_hi_late", memBus.regWriteData_MEM, 32'h0);
        applyStimulus(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0); tick();
        checkOutput("mdrst_lo_late", memBus.regWriteData_MEM, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_level.md
Name: ex_level

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode/register-read stage.
- Consumes the decode stage's EX pipeline registers and applies MEM/WB operand forwarding.
- Computes ALU results and memory addresses, and runs a multi-cycle multiply/divide unit (MDU) holding HI/LO.
- Drives the EX/MEM pipeline registers, the EX-level forward pair back to decode, and the MDU busy signal to the hazard unit.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU after the issue cycle
DIV_CYCLES, 10, busy cycles for DIV/DIVU after the issue cycle

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
instr_EX  input  WIDTH_INSTR  instruction symbol from decode
PC_EX  input  32  instruction PC
dataRs_EX  input  32  rs value latched at decode
dataRt_EX  input  32  rt value latched at decode
imm16_EX  input  16  immediate field
shamt_EX  input  5  shift amount field
addrRs_EX  input  5  rs index
addrRt_EX  input  5  rt index
regWriteAddr_EX  input  5  destination register; 0 = none
regWriteData_EX  input  32  early result (JAL/JALR link, LUI value), else 0
regaddr_MEM  input  5  MEM-stage destination, forwarding
regdata_MEM  input  32  MEM-stage result, forwarding
regaddr_WB  input  5  WB-stage destination, forwarding
regdata_WB  input  32  WB-stage result, forwarding
regaddr_EX  output  5  forward address to decode
regdata_EX  output  32  forward data to decode
md_busy  output  1  MDU occupied, combinational
instr_MEM  output  WIDTH_INSTR  registered instruction symbol
PC_MEM  output  32  registered PC
aluOut_MEM  output  32  registered ALU result / memory address
dataRt_MEM  output  32  registered forwarded rt, store data
regWriteAddr_MEM  output  5  registered destination
regWriteData_MEM  output  32  registered result, 0 for loads

Behaviour:
- Operand forwarding for rs and rt, in this priority:
  - MEM when regaddr_MEM==addr and addr!=0;
  - else WB on the same rule;
  - else the latched dataRs_EX/dataRt_EX.
- Immediate extension: zero-extend for ANDI/ORI/XORI; sign-extend for all other I-type, including SLTIU.
- ALU operations:
  - ADD/ADDU/ADDI/ADDIU: rs+B. SUB/SUBU: rs-rt. No overflow trap; ADD behaves as ADDU.
  - AND/OR/XOR/NOR as named. SLT/SLTI signed; SLTU/SLTIU unsigned. Result is 1 or 0.
  - SLL/SRL/SRA shift rt by shamt; SLLV/SRLV/SRAV shift by rs[4:0]; SRA/SRAV arithmetic.
  - Loads/stores: aluOut = rs + signext(imm).
- Result selection:
  - Register-writing ALU ops and MFHI/MFLO: regWriteData_MEM = ALU/HI/LO value.
  - JAL/JALR/LUI: pass regWriteData_EX through.
  - Loads: 0 (data is produced in MEM).
  - Everything else: 0. NOP is all-zero.
- Forward to decode, combinational from inputs:
  - regaddr_EX = regWriteAddr_EX only for JAL/JALR/LUI, else 0.
  - regdata_EX = regWriteData_EX.
- EX/MEM register: updates every posedge with no stall input (the hazard unit bubbles by clearing ID's output). Reset zeroes all six outputs.
- MDU state: HI, LO, cnt, busy. Reset clears all to 0, including mid-operation; the pending result is discarded.
- MDU issue: when instr_EX is MULT/MULTU/DIV/DIVU and busy==0, the operation issues.
  - Operands are captured at that edge.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES, and busy goes to 1.
- MDU busy countdown: while busy, cnt decrements each edge. At the edge where cnt==1:
  - HI/LO are written;
  - busy goes to 0.
- MDU results:
  - MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
  - DIV: LO = signed quotient, HI = signed remainder, truncating toward zero; remainder takes the dividend's sign. DIVU: unsigned quotient and remainder.
  - Divide by zero: HI/LO unchanged, busy timing unchanged.
- md_busy = busy OR (instr_EX is MULT/MULTU/DIV/DIVU).
- Hazard contract: the hazard unit guarantees no MD-class instruction reaches EX while busy. If one does, it is ignored: no issue, no HI/LO write, and MFHI/MFLO return the current HI/LO.
- MTHI/MTLO: write forwarded rs to HI/LO at the EX edge. MFHI/MFLO read HI/LO combinationally in the EX cycle.

Test Plan:
- ADDU rs=0x7FFFFFFF, rt=1 -> regWriteData_MEM=0x80000000 next edge; ADD with the same operands gives the same result, no trap.
- SLTI rs=0xFFFFFFFF, imm=0x0001 -> 1; SLTIU same operands -> 0; ANDI imm=0x8000 zero-extends, so 0xFFFFFFFF&imm = 0x00008000.
- Forward priority: addrRs=5, regaddr_MEM=5 (data 0x11), regaddr_WB=5 (data 0x22) -> 0x11 used; addrRs=0 with both addrs 0 -> latched dataRs used.
- MULT 0xFFFFFFFF×2 -> md_busy=1 in the issue cycle plus 5 following cycles, then 0; HI=0xFFFFFFFF, LO=0xFFFFFFFE; MFHI afterwards returns 0xFFFFFFFF.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles; DIVU x/0 -> HI/LO unchanged.
- Reset asserted at busy cycle 3 of a DIV -> next edge busy=0, cnt=0, HI=LO=0, all *_MEM outputs 0; a subsequent MFLO returns 0.
